// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- serial UART transmitter
//
// Sends one 11-bit frame per accepted byte on a single line that idles high:
//   start (0), D0..D7 LSB first, even parity (^byte), stop (1)
// Each bit is held for CLK_CY_PER_BIT clock cycles. The frame format matches
// uart_rx bit-for-bit, so o_Tx_Serial can drive its serial input directly.
//
// Parameters
//   CLK_CY_PER_BIT  clock cycles per serial bit (>= 2), default 87
//
// Ports
//   i_clk        in   1  system clock, rising edge
//   i_rst_n      in   1  reset, asynchronous assert, synchronous release, active-low
//   i_Tx_Dv      in   1  byte-valid strobe
//   i_Tx_Byte    in   8  byte to send, captured when i_Tx_Dv && o_Tx_Ready
//   o_Tx_Ready   out  1  a byte can be accepted this cycle
//   o_Tx_Active  out  1  frame in progress (start bit through stop bit)
//   o_Tx_Serial  out  1  serial line
//   o_Tx_Done    out  1  one-cycle pulse in the cycle after the last stop-bit cycle
//
// Build option
//   UART_TX_HOLD_BUF_EN  adds a one-entry holding register so the next byte can
//                        be accepted while a frame is in flight; frames then
//                        chain back-to-back with no idle bit between them.
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLK_CY_PER_BIT = 87
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_Tx_Dv,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam int CNT_W = (CLK_CY_PER_BIT > 1) ? $clog2(CLK_CY_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_CY_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Reset synchroniser: assertion reaches every flop at once (line goes high
  // immediately), release is aligned to i_clk so no flop sees a partial edge.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_n = rst_pipe[1];

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             parity_q;
  logic             done_q;

  logic             bit_end;
  logic             frame_end;
  logic             accept;
  logic             load;
  logic [7:0]       load_byte;

  assign bit_end   = (cnt_q == CNT_LAST);
  assign frame_end = (state_q == S_STOP) && bit_end;
  assign accept    = i_Tx_Dv && o_Tx_Ready;

`ifdef UART_TX_HOLD_BUF_EN
  logic [7:0] hold_q;
  logic       hold_full_q;
  logic       hold_wr;

  assign o_Tx_Ready = !hold_full_q;

  // A byte arriving while idle goes straight to the shifter; one arriving
  // mid-frame parks in the holding register. At the end of the stop bit the
  // parked byte (or one accepted in that very cycle) starts the next frame.
  assign load      = ((state_q == S_IDLE) && accept) ||
                     (frame_end && (hold_full_q || accept));
  assign load_byte = hold_full_q ? hold_q : i_Tx_Byte;
  assign hold_wr   = accept && (state_q != S_IDLE) && !frame_end;

  // NOTE: the holding register is cleared on reset too, so a byte buffered
  // before reset can never leak into the first frame after release.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
    end else if (hold_wr) begin
      hold_q      <= i_Tx_Byte;
      hold_full_q <= 1'b1;
    end else if (frame_end && hold_full_q) begin
      hold_full_q <= 1'b0;
    end
  end
`else
  assign o_Tx_Ready = (state_q == S_IDLE);
  assign load       = (state_q == S_IDLE) && accept;
  assign load_byte  = i_Tx_Byte;
`endif

  // NOTE: every register below is written with non-blocking assignments so all
  // of them update from the same pre-edge values, whatever the statement order.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      parity_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // Bit-period counter runs in every non-idle state and wraps each bit.
      if (state_q == S_IDLE || bit_end) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      // Wraps 7 -> 0 on leaving DATA, ready for the next frame.
      if (state_q == S_DATA && bit_end) begin
        bit_idx_q <= bit_idx_q + 3'd1;
      end

      if (load) begin
        shift_q  <= load_byte;
        parity_q <= ^load_byte;
      end

      done_q <= frame_end;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets its default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (load) state_d = S_START;
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA:   if (bit_end && bit_idx_q == 3'd7) state_d = S_PARITY;
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (bit_end) state_d = load ? S_START : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state, so the line is glitch-free per bit
  // and returns high the moment reset forces IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_Tx_Serial = 1'b1;
    unique case (state_q)
      S_IDLE:   o_Tx_Serial = 1'b1;
      S_START:  o_Tx_Serial = 1'b0;
      S_DATA:   o_Tx_Serial = shift_q[bit_idx_q];
      S_PARITY: o_Tx_Serial = parity_q;
      S_STOP:   o_Tx_Serial = 1'b1;
      default:  o_Tx_Serial = 1'b1;
    endcase
  end

  assign o_Tx_Active = (state_q != S_IDLE);
  assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx (CLK_CY_PER_BIT = 87).
// Expected frames are hand-written 11-bit vectors, bit 0 = start bit.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int BIT   = 87;
  localparam int FRAME = 11 * BIT;
`ifdef UART_TX_HOLD_BUF_EN
  localparam int RDY_IN_FRAME = FRAME;  // buffer empty: ready all frame long
`else
  localparam int RDY_IN_FRAME = 0;
`endif

  logic       i_clk;
  logic       i_rst_n;
  logic       i_Tx_Dv;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Ready;
  logic       o_Tx_Active;
  logic       o_Tx_Serial;
  logic       o_Tx_Done;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx #(.CLK_CY_PER_BIT(BIT)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_Tx_Dv     (i_Tx_Dv),
    .i_Tx_Byte   (i_Tx_Byte),
    .o_Tx_Ready  (o_Tx_Ready),
    .o_Tx_Active (o_Tx_Active),
    .o_Tx_Serial (o_Tx_Serial),
    .o_Tx_Done   (o_Tx_Done)
  );

  initial i_clk = 1'b0;
  always #50 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_Tx_Dv   = 1'b1;
    i_Tx_Byte = b;
    tick();
    i_Tx_Dv   = 1'b0;
  endtask

  // Entered in cycle 0 of the start bit; leaves in the cycle after the last
  // stop-bit cycle. Optionally strobes inj_byte at frame cycle inject_at.
  task automatic check_frame(input string tag, input logic [7:0] exp_byte,
                             input logic [10:0] exp_bits, input int inject_at,
                             input logic [7:0] inj_byte, input int exp_rdy);
    int         match [11];
    logic [10:0] rx;
    int         rdy_cnt;
    int         done_cnt;
    int         inact_cnt;
    int         b;
    for (int k = 0; k < 11; k++) match[k] = 0;
    rx        = '0;
    rdy_cnt   = 0;
    done_cnt  = 0;
    inact_cnt = 0;
    for (int n = 0; n < FRAME; n++) begin
      b = n / BIT;
      if (o_Tx_Serial === exp_bits[b]) match[b]++;
      if ((n % BIT) == BIT / 2) rx[b] = o_Tx_Serial;
      if (n > inject_at && o_Tx_Ready) rdy_cnt++;
      if (n > 0 && o_Tx_Done) done_cnt++;
      if (!o_Tx_Active) inact_cnt++;
      if (n == 1) i_Tx_Byte = 8'($urandom);
      if (n == inject_at) begin
        i_Tx_Dv   = 1'b1;
        i_Tx_Byte = inj_byte;
      end else begin
        i_Tx_Dv = 1'b0;
      end
      tick();
    end
    i_Tx_Dv = 1'b0;
    for (int k = 0; k < 11; k++)
      check($sformatf("%s_bit%0d_cycles", tag, k), match[k], BIT);
    check({tag, "_rx_byte"}, rx[8:1], exp_byte);
    check({tag, "_rx_parity"}, rx[9], exp_bits[9]);
    check({tag, "_ready_in_frame"}, rdy_cnt, exp_rdy);
    check({tag, "_early_done"}, done_cnt, 0);
    check({tag, "_inactive_cycles"}, inact_cnt, 0);
  endtask

  // Done cycle of a frame that is not followed by another.
  task automatic check_done_idle(input string tag);
    check({tag, "_done"}, o_Tx_Done, 1'b1);
    check({tag, "_active_drop"}, o_Tx_Active, 1'b0);
    check({tag, "_line_high"}, o_Tx_Serial, 1'b1);
    check({tag, "_ready_back"}, o_Tx_Ready, 1'b1);
    tick();
    check({tag, "_done_one_cycle"}, o_Tx_Done, 1'b0);
  endtask

  initial begin
    int bad_line;
    int bad_done;
    int bad_active;

    i_rst_n   = 1'b0;
    i_Tx_Dv   = 1'b0;
    i_Tx_Byte = 8'h00;
    #1;
    check("rst_serial", o_Tx_Serial, 1'b1);
    check("rst_active", o_Tx_Active, 1'b0);
    check("rst_done", o_Tx_Done, 1'b0);
    check("rst_ready", o_Tx_Ready, 1'b1);
    repeat (4) tick();
    i_rst_n = 1'b1;

    // 1. idle for 20 cycles after release
    bad_line = 0; bad_done = 0; bad_active = 0;
    repeat (20) begin
      tick();
      if (o_Tx_Serial !== 1'b1) bad_line++;
      if (o_Tx_Done !== 1'b0) bad_done++;
      if (o_Tx_Active !== 1'b0) bad_active++;
    end
    check("idle_line_low_cycles", bad_line, 0);
    check("idle_done_cycles", bad_done, 0);
    check("idle_active_cycles", bad_active, 0);
    check("idle_ready", o_Tx_Ready, 1'b1);

    // 2. 8'h8B -> 0,1,1,0,1,0,0,0,1,0,1
    send(8'h8B);
    check("f8b_start_low", o_Tx_Serial, 1'b0);
    check("f8b_active", o_Tx_Active, 1'b1);
    check_frame("f8b", 8'h8B, 11'b101_0001_0110, -1, 8'h00, RDY_IN_FRAME);
    check_done_idle("f8b");

    // 3. 8'h01 -> parity 1
    repeat (3) tick();
    send(8'h01);
    check_frame("f01", 8'h01, 11'b110_0000_0010, -1, 8'h00, RDY_IN_FRAME);
    check_done_idle("f01");
    repeat (3) tick();

`ifdef UART_TX_HOLD_BUF_EN
    // 5. 8'h55 then 8'hAA mid-frame -> back-to-back frames
    send(8'h55);
    check_frame("f55", 8'h55, 11'b100_1010_1010, 100, 8'hAA, 0);
    check("chain_done", o_Tx_Done, 1'b1);
    check("chain_active", o_Tx_Active, 1'b1);
    check("chain_start_low", o_Tx_Serial, 1'b0);
    check("chain_ready_back", o_Tx_Ready, 1'b1);
    check_frame("faa", 8'hAA, 11'b101_0101_0100, -1, 8'h00, FRAME);
    check_done_idle("faa");
`else
    // 4. strobe 8'hFF at START+10 -> dropped
    send(8'h3C);
    check_frame("f3c", 8'h3C, 11'b100_0111_1000, 10, 8'hFF, 0);
    check_done_idle("f3c");
    bad_line = 0; bad_active = 0;
    repeat (100) begin
      if (o_Tx_Serial !== 1'b1) bad_line++;
      if (o_Tx_Active !== 1'b0) bad_active++;
      tick();
    end
    check("drop_no_second_frame", bad_line, 0);
    check("drop_stays_idle", bad_active, 0);
`endif

    // 6. reset in DATA bit 3, then a clean 8'h8B
    repeat (3) tick();
    send(8'h8B);
    repeat (4 * BIT + 20) tick();
    check("mid_active_before_rst", o_Tx_Active, 1'b1);
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_line_high", o_Tx_Serial, 1'b1);
    check("mid_rst_active", o_Tx_Active, 1'b0);
    check("mid_rst_ready", o_Tx_Ready, 1'b1);
    bad_done = 0; bad_line = 0;
    repeat (5) begin
      tick();
      if (o_Tx_Done !== 1'b0) bad_done++;
    end
    i_rst_n = 1'b1;
    repeat (20) begin
      tick();
      if (o_Tx_Done !== 1'b0) bad_done++;
      if (o_Tx_Serial !== 1'b1) bad_line++;
    end
    check("mid_rst_no_done", bad_done, 0);
    check("mid_rst_line_idle", bad_line, 0);
    send(8'h8B);
    check_frame("post_rst", 8'h8B, 11'b101_0001_0110, -1, 8'h00, RDY_IN_FRAME);
    check_done_idle("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
